icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache.
- Responds to the pipeline's instruction-fetch request on the datapath/cache interface (imemREN, imemaddr → ihit, imemload).
- Fills misses from the memory controller over a simple request/wait handshake.
- Sits between the datapath's fetch stage and the memory arbiter; one word per block.

Parameters:
- SETS, 16, number of frames; power of two, ≥2.
- IDX_W, $clog2(SETS), index width (derived, not overridden).
- CNT_W, 32, width of hit/miss statistics counters.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  synchronous active-low reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  fetched instruction.
- halt  in  1  datapath halted; freezes statistics counters.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; iload valid when iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  CNT_W  saturating count of hit cycles.
- miss_count  out  CNT_W  saturating count of misses, counted at fill start.

Behaviour:
- Address split:
  - tag = imemaddr[31:IDX_W+2]
  - idx = imemaddr[IDX_W+1:2]
- Frame storage: SETS × {valid, tag, data}.
- Reset (nRST=0 at posedge):
  - all valid bits cleared; state ← IDLE; both counters ← 0.
  - tag/data arrays need not reset.
  - Outputs during and after reset: ihit=0, imemload=0, iREN=0.
- FSM states: IDLE, FETCH.
- IDLE:
  - hit = imemREN & valid[idx] & (tag_arr[idx]==tag).
  - ihit = hit, combinational (same-cycle, zero-latency hit).
  - imemload = data[idx] when hit, else 0.
  - iREN=0.
  - imemREN=1 and not hit → next state FETCH; miss_count++.
  - imemREN=0 → stay IDLE; ihit=0.
- FETCH:
  - iREN=1; iaddr = {imemaddr[31:2],2'b00}; ihit=0; imemload=0.
  - iwait=1 → stay in FETCH.
  - iwait=0 → write iload and tag into frame idx, set valid, go to IDLE.
  - Next cycle hits in IDLE: miss latency = memory latency + 1 cycle.
  - The fill address is the live imemaddr, not latched. The datapath holds PC stable while ihit=0. If imemaddr changes mid-fill, the fill targets the address present on the iwait=0 cycle (no stale frame written).
  - imemREN dropping mid-FETCH does not abort the fill; the transaction completes and the state returns to IDLE.
- iaddr outside FETCH: {imemaddr[31:2],2'b00}, don't-care to memory.
- Fill to a valid frame with a different tag: overwrite (evict), no writeback.
- Reset asserted mid-FETCH:
  - next cycle is IDLE with all frames invalid; iREN=0 immediately.
  - a pending memory response is ignored.
- Counters:
  - hit_count increments every cycle ihit=1.
  - miss_count increments on the IDLE→FETCH transition.
  - both saturate at all-ones.
  - neither increments while halt=1.
- halt does not block lookups.
- Timing constraint: no combinational path from iload to ihit/imemload; data is returned only from the array.

Decomposition:
- Add to shared cpu_types_pkg:
  - icache_frame_t (valid, tag, data).
  - icachef_t packed address struct (tag, idx, bytoff).
  - icache_state_t enum {IDLE, FETCH}.
- Single module; counter saturation logic is inline. No sub-module warranted.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000040, memory returns 0x8C010004 after 2 iwait cycles:
  - iREN=1 for 3 cycles; ihit=0.
  - next cycle ihit=1, imemload=0x8C010004; miss_count=1, hit_count=1.
- After that fill, re-read 0x00000040 for 5 cycles → ihit=1 every cycle, iREN=0, hit_count=5.
- Conflict:
  - fill 0x00000040 (idx 0), then read 0x00000440 (same idx, tag differs) → miss, iREN=1, iaddr=0x00000440.
  - after the fill, 0x00000040 misses again.
- Reset mid-fill:
  - assert nRST=0 during FETCH with iwait=1 → next cycle iREN=0, ihit=0, counters 0.
  - re-reading 0x00000040 misses.
- Stats:
  - halt=1 with continuous hits → hit_count frozen.
  - force counters to 0xFFFFFFFF via long run or parameter CNT_W=4 (16 hits) → holds at 0xF, no wrap.
- imemREN=0 during FETCH with iwait then 0, iload=0x12345678 → frame filled, state IDLE; a later read of the same address hits with 0x12345678.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared instruction-cache types and default geometry
package icache_pkg;
  localparam int ICACHE_SETS = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;
  typedef enum logic {IDLE, FETCH} icache_state_t;
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0] bytoff;
  } icachef_t;
  typedef struct packed {
    logic valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0] data;
  } icache_frame_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: datapath fetch port, memory fill port and statistics of the instruction cache
interface icache_if #(parameter int CNT_W = 32);
  logic imemREN, ihit, halt, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
  logic [CNT_W-1:0] hit_count, miss_count;
  modport slave (
    input imemREN, imemaddr, halt, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
  modport master (
    output imemREN, imemaddr, halt, iwait, iload,
    input ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-block read-only instruction cache with hit/miss statistics
module icache import icache_pkg::*; #(
  parameter int SETS = 16,
  parameter int CNT_W = 32
) (
  input logic CLK,
  input logic nRST,
  icache_if.slave dcif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  icache_state_t state;
  logic [SETS-1:0] valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0] data [SETS];
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic hit, miss, fill;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  assign tag = dcif.imemaddr[31:IDX_W+2];
  assign idx = dcif.imemaddr[IDX_W+1:2];
  assign hit = dcif.imemREN && valid[idx] && tags[idx] == tag;
  assign miss = state == IDLE && dcif.imemREN && !hit;
  // fill uses the live address so a PC change mid-fill never writes a stale frame
  assign fill = state == FETCH && !dcif.iwait;
  always_comb begin
    dcif.ihit = nRST && state == IDLE && hit;
    dcif.imemload = dcif.ihit ? data[idx] : '0;
    dcif.iREN = nRST && state == FETCH;
    dcif.iaddr = {dcif.imemaddr[31:2], 2'b00};
    dcif.hit_count = hit_cnt;
    dcif.miss_count = miss_cnt;
  end
  always_ff @(posedge CLK)
    if (!nRST) begin
      state <= IDLE;
      valid <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state <= miss ? FETCH : fill ? IDLE : state;
      if (fill) valid[idx] <= 1'b1;
      if (dcif.ihit && !dcif.halt && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
      if (miss && !dcif.halt && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
    end
  always_ff @(posedge CLK)
    if (nRST && fill) begin
      tags[idx] <= tag;
      data[idx] <= dcif.iload;
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed and randomized checks of icache against a frame-array reference model
module tb_icache;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  icache_if #(.CNT_W(CW)) dcif();
  icache #(.SETS(16), .CNT_W(CW)) dut (.CLK(CLK), .nRST(nRST), .dcif(dcif));
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  bit m_valid [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_data [16];
  bit m_fetch;
  int m_hc, m_mc;
  int wait_left = 0, lat = 0;
  logic [31:0] ld = '0;
  logic [31:0] cur;

  function automatic bit m_hit();
    return dcif.imemREN && m_valid[dcif.imemaddr[5:2]] && m_tag[dcif.imemaddr[5:2]] == dcif.imemaddr[31:6];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frames updated at the clock edge from the spec's rules
  always @(posedge CLK)
    if (!nRST) begin
      m_valid = '{default: 1'b0};
      m_fetch = 1'b0;
      m_hc = 0;
      m_mc = 0;
    end else if (!m_fetch) begin
      if (m_hit()) begin
        if (!dcif.halt && m_hc < MAXC) m_hc++;
      end else if (dcif.imemREN) begin
        m_fetch = 1'b1;
        if (!dcif.halt && m_mc < MAXC) m_mc++;
      end
    end else if (!dcif.iwait) begin
      m_valid[dcif.imemaddr[5:2]] = 1'b1;
      m_tag[dcif.imemaddr[5:2]] = dcif.imemaddr[31:6];
      m_data[dcif.imemaddr[5:2]] = dcif.iload;
      m_fetch = 1'b0;
    end

  always @(negedge CLK)
    if (chk_en) begin
      logic eh;
      eh = nRST && !m_fetch && m_hit();
      chk("ihit", dcif.ihit, eh);
      chk("imemload", dcif.imemload, eh ? m_data[dcif.imemaddr[5:2]] : 32'h0);
      chk("iREN", dcif.iREN, nRST && m_fetch);
      chk("iaddr", dcif.iaddr, {dcif.imemaddr[31:2], 2'b00});
      chk("hit_count", dcif.hit_count, m_hc);
      chk("miss_count", dcif.miss_count, m_mc);
    end

  task automatic step(input bit rn, input bit ren, input bit hl, input logic [31:0] a);
    @(posedge CLK); #1;
    nRST = rn;
    dcif.imemREN = ren;
    dcif.halt = hl;
    dcif.imemaddr = a;
    dcif.iload = ld;
    #1;
    if (dcif.iREN) begin
      dcif.iwait = wait_left != 0;
      if (wait_left != 0) wait_left--;
    end else begin
      wait_left = lat;
      dcif.iwait = 1'($urandom_range(0, 1));
    end
    @(negedge CLK); #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d, input int l);
    int n;
    n = 0;
    ld = d;
    lat = l;
    step(1, 1, 0, a);
    while (!dcif.ihit && n < 20) begin
      step(1, 1, 0, a);
      n++;
    end
    chk("fill_done", dcif.ihit, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    dcif.imemREN = 0; dcif.imemaddr = 0; dcif.halt = 0; dcif.iwait = 0; dcif.iload = 0;
    step(0, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 1, 0, 32'h40);
    chk("rst_ihit", dcif.ihit, 0);
    chk("rst_iren", dcif.iREN, 0);
    chk("rst_imemload", dcif.imemload, 0);
    // first miss: two wait cycles then data
    ld = 32'h8C010004; lat = 2;
    step(1, 1, 0, 32'h40);
    chk("miss_ihit", dcif.ihit, 0);
    chk("miss_iren", dcif.iREN, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 32'h40);
      chk("fetch_iren", dcif.iREN, 1);
      chk("fetch_ihit", dcif.ihit, 0);
    end
    step(1, 1, 0, 32'h40);
    chk("first_hit", dcif.ihit, 1);
    chk("first_data", dcif.imemload, 32'h8C010004);
    chk("first_miss_cnt", dcif.miss_count, 1);
    step(1, 1, 0, 32'h40);
    chk("first_hit_cnt", dcif.hit_count, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 32'h40);
      chk("rehit", dcif.ihit, 1);
      chk("rehit_iren", dcif.iREN, 0);
    end
    step(1, 0, 0, 32'h40);
    chk("hit_cnt5", dcif.hit_count, 5);
    // conflict eviction on index 0
    ld = 32'hAAAA0440; lat = 1;
    step(1, 1, 0, 32'h440);
    chk("conf_miss", dcif.ihit, 0);
    step(1, 1, 0, 32'h440);
    chk("conf_iren", dcif.iREN, 1);
    chk("conf_iaddr", dcif.iaddr, 32'h440);
    fill(32'h440, 32'hAAAA0440, 1);
    chk("conf_data", dcif.imemload, 32'hAAAA0440);
    step(1, 1, 0, 32'h40);
    chk("evicted", dcif.ihit, 0);
    fill(32'h40, 32'h8C010004, 0);
    // reset in the middle of a fill
    lat = 5;
    step(1, 1, 0, 32'h80);
    step(1, 1, 0, 32'h80);
    chk("mid_iren", dcif.iREN, 1);
    step(0, 1, 0, 32'h80);
    chk("rst_mid_iren", dcif.iREN, 0);
    step(1, 0, 0, 32'h80);
    chk("post_rst_iren", dcif.iREN, 0);
    chk("post_rst_hc", dcif.hit_count, 0);
    chk("post_rst_mc", dcif.miss_count, 0);
    step(1, 1, 0, 32'h40);
    chk("post_rst_miss", dcif.ihit, 0);
    fill(32'h40, 32'h8C010004, 0);
    // halt freezes counters but not lookups
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 32'h40);
      chk("halt_hit", dcif.ihit, 1);
    end
    step(1, 0, 0, 32'h40);
    chk("halt_frozen", dcif.hit_count, 1);
    // imemREN drops mid-fill; fill still completes
    lat = 2;
    step(1, 1, 0, 32'h100);
    n = 0;
    ld = 32'h12345678;
    do begin
      step(1, 0, 0, 32'h100);
      n++;
    end while (dcif.iREN && n < 20);
    chk("drop_iren", dcif.iREN, 0);
    ld = 32'h0;
    step(1, 1, 0, 32'h100);
    chk("drop_hit", dcif.ihit, 1);
    chk("drop_data", dcif.imemload, 32'h12345678);
    // counter saturation
    for (int i = 0; i < 300; i++) step(1, 1, 0, 32'h100);
    step(1, 0, 0, 32'h100);
    chk("sat_hc", dcif.hit_count, MAXC);
    step(1, 1, 0, 32'h100);
    step(1, 0, 0, 32'h100);
    chk("sat_hold", dcif.hit_count, MAXC);
    // randomized traffic over a small address pool
    cur = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0)
        cur = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      ld = $urandom;
      lat = $urandom_range(0, 3);
      step($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, cur);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
